// File: rtl/demux16_sched.sv
`default_nettype none
// ============================================================================
//  Module      : demux16_sched
//  Description : Sequencing front-end for a 16-bit 1-to-4 demux datapath.
//                One valid/ready producer stream is steered to one of four
//                sink channels. Each channel is backed by a small FIFO. The
//                destination comes from in_sel (directed mode) or from a
//                round-robin scheduler that skips full channels (rr mode).
//  Ports       :
//    clk        rising-edge clock, single domain
//    rst_n      synchronous reset, active low
//    in_valid   producer has a word
//    in_data    producer word (WIDTH bits)
//    in_sel     destination channel, used in directed mode only
//    rr_mode    1 = round-robin destination, in_sel ignored
//    in_ready   word accepted this cycle when in_valid & in_ready
//    out_valid  per-channel FIFO non-empty
//    out_data   channel i head word at [i*WIDTH +: WIDTH]
//    out_ready  consumer i pops its head when out_valid[i] & out_ready[i]
//    busy       any channel FIFO non-empty
//  Revision    : 1.0  initial release
// ============================================================================
module demux16_sched #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   input  logic               rr_mode,
   output logic               in_ready,
   output logic [3:0]         out_valid,
   output logic [4*WIDTH-1:0] out_data,
   input  logic [3:0]         out_ready,
   output logic               busy
);

   localparam int C_AW = $clog2(DEPTH);   // FIFO pointer width
   localparam int C_CW = C_AW + 1;        // FIFO occupancy width
   localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

   // ------------------------------------------------------------------------
   // Shared state and selection signals
   // ------------------------------------------------------------------------
   logic [1:0] rr_ptr_q;
   logic [1:0] rr_ptr_d;
   logic [3:0] full;        // registered-state full flag per channel
   logic [1:0] tgt;         // destination of the current word
   logic [1:0] cand;        // round-robin candidate being examined
   logic       ready_raw;   // target has room (before reset gating)
   logic       accept;      // word transferred this cycle

   // ------------------------------------------------------------------------
   // Target selection. Only registered full flags are used, so a pop in the
   // same cycle never opens a slot for a push, and in_ready never depends on
   // in_valid.
   // ------------------------------------------------------------------------
   always_comb begin
      tgt       = in_sel;
      cand      = rr_ptr_q;
      ready_raw = !full[in_sel];
      if (rr_mode) begin
         tgt       = rr_ptr_q;
         ready_raw = 1'b0;
         // Scan from the farthest offset down to offset 0 so the channel
         // closest to rr_ptr (in rotation order) is the one that sticks.
         for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (!full[cand]) begin
               tgt       = cand;
               ready_raw = 1'b1;
            end
         end
      end
   end

   // Nothing is accepted while reset is asserted.
   assign in_ready = rst_n & ready_raw;
   assign accept   = in_valid & in_ready;

   // The scheduler pointer only moves on a round-robin accept; it points one
   // past the channel just served and wraps naturally at 2 bits.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (rr_mode && accept) begin
         rr_ptr_d = tgt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= 2'd0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Per-channel FIFOs
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < 4; i++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [C_AW-1:0]  wr_ptr_q;
      logic [C_AW-1:0]  wr_ptr_d;
      logic [C_AW-1:0]  rd_ptr_q;
      logic [C_AW-1:0]  rd_ptr_d;
      logic [C_CW-1:0]  count_q;
      logic [C_CW-1:0]  count_d;
      logic             push;
      logic             pop;

      assign push = accept & (tgt == 2'(i));
      // out_valid gating means an empty channel can never be popped.
      assign pop  = out_valid[i] & out_ready[i];

      always_comb begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
         end
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;

         if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + C_AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + C_AW'(1);
         end

         // Push and pop together leave the level unchanged.
         case ({push, pop})
            2'b10:   count_d = count_q + C_CW'(1);
            2'b01:   count_d = count_q - C_CW'(1);
            default: count_d = count_q;
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            // Storage is cleared too so out_data reads zero after reset.
            for (int k = 0; k < DEPTH; k++) begin
               mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            for (int k = 0; k < DEPTH; k++) begin
               mem_q[k] <= mem_d[k];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
         end
      end

      assign full[i]                      = (count_q == C_FULL);
      assign out_valid[i]                 = (count_q != '0);
      assign out_data[i*WIDTH +: WIDTH]   = mem_q[rd_ptr_q];
   end

   assign busy = |out_valid;

endmodule
`default_nettype wire

// File: tb/tb_demux16_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux16_sched
//  Description : Self-checking bench for demux16_sched. A queue-per-channel
//                reference model with an integer round-robin pointer
//                predicts readiness, occupancy and head words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux16_sched;

   localparam int WIDTH = 16;
   localparam int DEPTH = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic               rr_mode;
   logic               in_ready;
   logic [3:0]         out_valid;
   logic [4*WIDTH-1:0] out_data;
   logic [3:0]         out_ready;
   logic               busy;

   int vectors = 0;
   int errs    = 0;

   // Reference model: one queue per channel plus the scheduler pointer.
   logic [WIDTH-1:0] mq [4][$];
   int               mptr = 0;

   demux16_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .rr_mode   (rr_mode),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   function automatic int m_tgt();
      if (!rr_mode) return int'(in_sel);
      for (int off = 0; off < 4; off++) begin
         int c;
         c = (mptr + off) % 4;
         if (mq[c].size() < DEPTH) return c;
      end
      return -1;
   endfunction

   function automatic bit m_ready();
      int t;
      if (!rst_n) return 1'b0;
      t = m_tgt();
      if (t < 0) return 1'b0;
      return mq[t].size() < DEPTH;
   endfunction

   function automatic logic [3:0] m_valid();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = (mq[i].size() > 0);
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] head(input int ch);
      return out_data[ch*WIDTH +: WIDTH];
   endfunction

   // Advance one clock, updating the model with what should happen at it.
   task automatic tick();
      bit               acc;
      int               t;
      bit [3:0]         pops;
      logic [WIDTH-1:0] d;
      acc = in_valid && m_ready();
      t   = m_tgt();
      d   = in_data;
      for (int i = 0; i < 4; i++) pops[i] = out_ready[i] && (mq[i].size() > 0);
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mq[i].delete();
         mptr = 0;
      end else begin
         for (int i = 0; i < 4; i++) if (pops[i]) void'(mq[i].pop_front());
         if (acc) begin
            mq[t].push_back(d);
            if (rr_mode) mptr = (t + 1) % 4;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
      rr_mode = 1'b0; out_ready = 4'b0000;
      tick(); tick();
      rst_n = 1'b1;
      #1;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
      rr_mode = 1'b0; out_ready = 4'b0000;
      tick(); tick();
      vectors++; if (out_valid !== 4'b0000) begin errs++; $display("FAIL rst_valid got=%b exp=0000", out_valid); end
      vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
      vectors++; if (out_data !== 64'h0) begin errs++; $display("FAIL rst_data got=%h exp=0", out_data); end
      vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_low got=%b exp=0", in_ready); end
      rst_n = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_high got=%b exp=1", in_ready); end
   endtask

   task automatic test_directed();
      do_reset();
      in_sel = 2'd2; in_data = 16'hA5A5; in_valid = 1'b1; #1;
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL dir_ready1 got=%b exp=1", in_ready); end
      tick();
      in_data = 16'h1111; #1;
      vectors++; if (out_valid !== 4'b0100) begin errs++; $display("FAIL dir_valid got=%b exp=0100", out_valid); end
      vectors++; if (head(2) !== 16'hA5A5) begin errs++; $display("FAIL dir_head got=%h exp=a5a5", head(2)); end
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL dir_ready2 got=%b exp=1", in_ready); end
      tick();
      in_data = 16'h2222; #1;
      vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL dir_full got=%b exp=0", in_ready); end
      tick();
      vectors++; if (head(2) !== 16'hA5A5) begin errs++; $display("FAIL dir_stable got=%h exp=a5a5", head(2)); end
      out_ready = 4'b0100; #1;
      vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL dir_pop_same_cycle got=%b exp=0", in_ready); end
      tick();
      out_ready = 4'b0000; #1;
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL dir_after_pop got=%b exp=1", in_ready); end
      vectors++; if (head(2) !== 16'h1111) begin errs++; $display("FAIL dir_head2 got=%h exp=1111", head(2)); end
      tick();
      in_valid = 1'b0; out_ready = 4'b0100; #1;
      tick();
      vectors++; if (head(2) !== 16'h2222) begin errs++; $display("FAIL dir_head3 got=%h exp=2222", head(2)); end
      tick();
      out_ready = 4'b0000; #1;
      vectors++; if (out_valid !== 4'b0000) begin errs++; $display("FAIL dir_drained got=%b exp=0000", out_valid); end
   endtask

   task automatic test_rr();
      logic [WIDTH-1:0] exp_h [4];
      exp_h[0] = 16'd1; exp_h[1] = 16'd2; exp_h[2] = 16'd3; exp_h[3] = 16'd4;
      do_reset();
      rr_mode = 1'b1; in_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         in_data = WIDTH'(k); in_sel = 2'($urandom_range(0, 3)); #1;
         vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rr_ready%0d got=%b exp=1", k, in_ready); end
         tick();
      end
      in_valid = 1'b0; #1;
      vectors++; if (out_valid !== 4'b1111) begin errs++; $display("FAIL rr_valid got=%b exp=1111", out_valid); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (head(i) !== exp_h[i]) begin errs++; $display("FAIL rr_head%0d got=%h exp=%h", i, head(i), exp_h[i]); end
      end
      out_ready = 4'b0001; tick(); out_ready = 4'b0000; #1;
      vectors++; if (head(0) !== 16'd5) begin errs++; $display("FAIL rr_wrap got=%h exp=0005", head(0)); end
      // rr_ptr now 1 and ch1 still has room: the next word joins ch1.
      in_valid = 1'b1; in_data = 16'd6; tick(); in_valid = 1'b0;
      out_ready = 4'b0010; #1;
      vectors++; if (head(1) !== 16'd2) begin errs++; $display("FAIL rr_ch1a got=%h exp=0002", head(1)); end
      tick();
      vectors++; if (head(1) !== 16'd6) begin errs++; $display("FAIL rr_ch1b got=%h exp=0006", head(1)); end
      out_ready = 4'b0000;
   endtask

   task automatic test_rr_skip();
      do_reset();
      rr_mode = 1'b1; in_valid = 1'b1; in_data = 16'h0010; tick();  // ch0, ptr->1
      rr_mode = 1'b0; in_sel = 2'd1;
      in_data = 16'h0011; tick();
      in_data = 16'h0012; tick();
      rr_mode = 1'b1; in_data = 16'h0077; #1;
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL skip_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0; #1;
      vectors++; if (out_valid !== 4'b0111) begin errs++; $display("FAIL skip_valid got=%b exp=0111", out_valid); end
      vectors++; if (head(2) !== 16'h0077) begin errs++; $display("FAIL skip_head got=%h exp=0077", head(2)); end
      in_valid = 1'b1; in_data = 16'h0088; tick();                   // ptr was 3 -> ch3
      vectors++; if (out_valid !== 4'b1111) begin errs++; $display("FAIL skip_ptr3 got=%b exp=1111", out_valid); end
      for (int k = 0; k < 4; k++) begin
         in_data = 16'h0100 + 16'(k); #1;
         vectors++; if (in_ready !== m_ready()) begin errs++; $display("FAIL skip_fill%0d got=%b exp=%b", k, in_ready, m_ready()); end
         tick();
      end
      vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL skip_allfull got=%b exp=0", in_ready); end
      in_valid = 1'b0; out_ready = 4'b1111;
      for (int n = 0; n < 3; n++) begin
         #1;
         for (int i = 0; i < 4; i++) if (mq[i].size() > 0) begin
            vectors++; if (head(i) !== mq[i][0]) begin errs++; $display("FAIL skip_drain ch%0d got=%h exp=%h", i, head(i), mq[i][0]); end
         end
         tick();
      end
      out_ready = 4'b0000; #1;
      vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL skip_busy got=%b exp=0", busy); end
   endtask

   task automatic test_concurrent();
      do_reset();
      in_sel = 2'd0; in_valid = 1'b1; in_data = 16'h0A0A; tick();
      in_data = 16'h0B0B; out_ready = 4'b0001; #1;
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL conc_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0; #1;
      vectors++; if (out_valid !== 4'b0001) begin errs++; $display("FAIL conc_valid got=%b exp=0001", out_valid); end
      vectors++; if (head(0) !== 16'h0B0B) begin errs++; $display("FAIL conc_head got=%h exp=0b0b", head(0)); end
      tick();
      out_ready = 4'b0000; #1;
      vectors++; if (out_valid !== 4'b0000) begin errs++; $display("FAIL conc_level got=%b exp=0000", out_valid); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         if (n % 97 == 0) rr_mode = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = 16'($urandom);
         out_ready = 4'($urandom);
         #1;
         vectors++; if (in_ready !== m_ready()) begin errs++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, in_ready, m_ready()); end
         vectors++; if (out_valid !== m_valid()) begin errs++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, m_valid()); end
         vectors++; if (busy !== (|m_valid())) begin errs++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, |m_valid()); end
         for (int i = 0; i < 4; i++) if (mq[i].size() > 0) begin
            vectors++; if (head(i) !== mq[i][0]) begin errs++; $display("FAIL rnd_head n=%0d ch%0d got=%h exp=%h", n, i, head(i), mq[i][0]); end
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 4'b1111;
      repeat (DEPTH + 1) tick();
      out_ready = 4'b0000; #1;
      vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL rnd_drain got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1'b1;
      in_sel = 2'd0; in_data = 16'h00C0; tick();
      in_sel = 2'd1; in_data = 16'h00C1; tick();
      in_sel = 2'd3; in_data = 16'h00C3; tick();
      rr_mode = 1'b1; in_data = 16'h00C4; tick();                    // ch0, ptr->1
      in_valid = 1'b0; rst_n = 1'b0; tick();
      vectors++; if (out_valid !== 4'b0000) begin errs++; $display("FAIL mid_valid got=%b exp=0000", out_valid); end
      vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got=%b exp=0", busy); end
      vectors++; if (out_data !== 64'h0) begin errs++; $display("FAIL mid_data got=%h exp=0", out_data); end
      rst_n = 1'b1; in_valid = 1'b1; in_data = 16'h0CCC; #1;
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0; #1;
      vectors++; if (out_valid !== 4'b0001) begin errs++; $display("FAIL mid_rr_ch0 got=%b exp=0001", out_valid); end
      vectors++; if (head(0) !== 16'h0CCC) begin errs++; $display("FAIL mid_head got=%h exp=0ccc", head(0)); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_rr();
      test_rr_skip();
      test_concurrent();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
`default_nettype wire
